// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: datapath widths, write-back request
// record and the write-back port encoding.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Also the encoding of the arbiter's last_grant state.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } wb_port_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port.
// The state (last_grant) is exposed as an output so it can be observed.
module wb_rr_arbiter
  import rv32i_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     a_valid,
  input  logic     b_valid,
  output logic     grant_a,
  output logic     grant_b,
  output wb_port_e last_grant
);

  wb_port_e last_grant_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_B;  // A wins the first conflict after reset
    end else begin
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    grant_a         = 1'b0;
    grant_b         = 1'b0;
    last_grant_next = last_grant;
    if (a_valid && (!b_valid || last_grant == PORT_B)) begin
      grant_a = 1'b1;
    end else if (b_valid) begin
      grant_b = 1'b1;
    end
    // A grant is always an acceptance, since ready equals grant.
    if (grant_a) begin
      last_grant_next = PORT_A;
    end else if (grant_b) begin
      last_grant_next = PORT_B;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: round-robin shares the register-file write port
// between A and B, registers the winner, and tracks pending writes for RAW hazards.
module regfile_wb_scheduler
  import rv32i_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = rv32i_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       rd_data
);

  // Handshake: a port's request is accepted in the cycle where valid && ready;
  // ready is combinational, never asserts without valid, and the requester
  // holds valid/rd/data stable until accepted.

  logic                grant_a;
  logic                grant_b;
  wb_port_e            last_grant;
  logic                accept_a;
  logic                accept_b;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  wb_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .last_grant (last_grant)
  );

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write <= 1'b0;
      rd        <= '0;
      rd_data   <= '0;
    end else if (accept_a) begin
      reg_write <= (a_rd != '0);
      rd        <= a_rd;
      rd_data   <= a_data;
    end else if (accept_b) begin
      reg_write <= (b_rd != '0);
      rd        <= b_rd;
      rd_data   <= b_data;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Set after clear: a newly issued writer owns the register even while an
  // older write to it commits in the same cycle.
  always_comb begin
    pending_next = pending;
    if (reg_write) begin
      pending_next[rd] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];

  // last_grant is kept visible on the arbiter for observation only.
  wire unused_last_grant = (last_grant == PORT_A);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler.
// Inputs change 1ns after each rising edge; every check samples away from the edge.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] rd_data;

  int n_checks;
  int n_fails;

  logic [36:0] exp_q[$];

  regfile_wb_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .reg_write   (reg_write),
    .rd          (rd),
    .rd_data     (rd_data)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid     = 1'b0;
    a_rd        = '0;
    a_data      = '0;
    b_valid     = 1'b0;
    b_rd        = '0;
    b_data      = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Ready during reset follows valid; A wins the first conflict.
    rst = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    rs1 = 5'd3;
    rs2 = 5'd0;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_ready: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
    end
    n_checks++;
    if (reg_write !== 1'b0 || rd !== 5'd0 || rd_data !== 32'd0) begin
      n_fails++;
      $display("FAIL reset_values: reg_write=%b rd=%0d rd_data=%h, required 0 0 0", reg_write, rd, rd_data);
    end
    do_reset();
    // Build up a write in the output stage, then reset it away mid-cycle.
    rs1 = 5'd3;
    issue_valid = 1'b1;
    issue_rd = 5'd3;
    a_valid = 1'b1;
    a_rd = 5'd3;
    a_data = 32'h0000_0055;
    next_cycle();
    idle_inputs();
    n_checks++;
    if (reg_write !== 1'b1 || rd !== 5'd3 || rs1_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_setup: reg_write=%b rd=%0d rs1_busy=%b, required 1 3 1", reg_write, rd, rs1_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (reg_write !== 1'b0 || rd !== 5'd0 || rd_data !== 32'd0) begin
      n_fails++;
      $display("FAIL reset_async: reg_write=%b rd=%0d rd_data=%h, required 0 0 0", reg_write, rd, rd_data);
    end
    n_checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_busy: rs1_busy=%b rs2_busy=%b, required 0 0", rs1_busy, rs2_busy);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_single_port();
    do_reset();
    a_valid = 1'b1;
    a_rd = 5'd5;
    a_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL single_ready: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
    end
    next_cycle();
    idle_inputs();
    n_checks++;
    if (reg_write !== 1'b1 || rd !== 5'd5 || rd_data !== 32'hDEAD_BEEF) begin
      n_fails++;
      $display("FAIL single_out: reg_write=%b rd=%0d rd_data=%h, required 1 5 deadbeef", reg_write, rd, rd_data);
    end
    next_cycle();
    n_checks++;
    if (reg_write !== 1'b0 || rd !== 5'd5 || rd_data !== 32'hDEAD_BEEF) begin
      n_fails++;
      $display("FAIL single_hold: reg_write=%b rd=%0d rd_data=%h, required 0 5 deadbeef", reg_write, rd, rd_data);
    end
  endtask

  task automatic test_contention();
    logic [4:0]  a_rds[2];
    logic [31:0] a_dats[2];
    logic [4:0]  b_rds[2];
    logic [31:0] b_dats[2];
    int ia;
    int ib;
    logic [36:0] exp;
    a_rds = '{5'd1, 5'd2};
    a_dats = '{32'hA000_0001, 32'hA000_0002};
    b_rds = '{5'd3, 5'd4};
    b_dats = '{32'hB000_0003, 32'hB000_0004};
    ia = 0;
    ib = 0;
    // Expected grant order A, B, A, B.
    exp_q.push_back({5'd1, 32'hA000_0001});
    exp_q.push_back({5'd3, 32'hB000_0003});
    exp_q.push_back({5'd2, 32'hA000_0002});
    exp_q.push_back({5'd4, 32'hB000_0004});
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1;
      a_rd = a_rds[ia];
      a_data = a_dats[ia];
      b_valid = 1'b1;
      b_rd = b_rds[ib];
      b_data = b_dats[ib];
      #1;
      n_checks++;
      if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin
        n_fails++;
        $display("FAIL contention_grant[%0d]: a_ready=%b b_ready=%b, required %b %b", k, a_ready, b_ready, k % 2 == 0, k % 2 == 1);
      end
      if (k % 2 == 0) ia++; else ib++;
      next_cycle();
      if (k == 3) idle_inputs();
      exp = exp_q.pop_front();
      n_checks++;
      if (reg_write !== 1'b1 || {rd, rd_data} !== exp) begin
        n_fails++;
        $display("FAIL contention_out[%0d]: reg_write=%b rd=%0d rd_data=%h, required 1 %0d %h", k, reg_write, rd, rd_data, exp[36:32], exp[31:0]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1;
      a_rd = 5'(10 + k);
      a_data = 32'h1000_0000 + 32'(k);
      next_cycle();
      n_checks++;
      if (reg_write !== 1'b1 || rd !== 5'(10 + k) || rd_data !== 32'h1000_0000 + 32'(k)) begin
        n_fails++;
        $display("FAIL back_to_back[%0d]: reg_write=%b rd=%0d rd_data=%h, required 1 %0d %h", k, reg_write, rd, rd_data, 10 + k, 32'h1000_0000 + 32'(k));
      end
    end
    idle_inputs();
  endtask

  task automatic test_x0_drop();
    do_reset();
    issue_valid = 1'b1;
    issue_rd = 5'd12;
    next_cycle();
    idle_inputs();
    rs1 = 5'd12;
    rs2 = 5'd0;
    b_valid = 1'b1;
    b_rd = 5'd0;
    b_data = 32'h0000_1234;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL x0_ready: b_ready=%b, required 1", b_ready);
    end
    next_cycle();
    idle_inputs();
    n_checks++;
    if (reg_write !== 1'b0) begin
      n_fails++;
      $display("FAIL x0_write: reg_write=%b, required 0", reg_write);
    end
    next_cycle();
    n_checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL x0_pending: rs1_busy=%b rs2_busy=%b, required 1 0", rs1_busy, rs2_busy);
    end
  endtask

  task automatic test_scoreboard();
    logic exp_busy[6];
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    rs1 = 5'd7;
    rs2 = 5'd0;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c == 0) begin
        issue_valid = 1'b1;
        issue_rd = 5'd7;
      end
      if (c == 3) begin
        a_valid = 1'b1;
        a_rd = 5'd7;
        a_data = 32'h7777_0007;
      end
      #1;
      n_checks++;
      if (rs1_busy !== exp_busy[c]) begin
        n_fails++;
        $display("FAIL scoreboard_busy[cycle %0d]: rs1_busy=%b, required %b", c, rs1_busy, exp_busy[c]);
      end
      if (c == 4) begin
        n_checks++;
        if (reg_write !== 1'b1 || rd !== 5'd7 || rd_data !== 32'h7777_0007) begin
          n_fails++;
          $display("FAIL scoreboard_commit: reg_write=%b rd=%0d rd_data=%h, required 1 7 77770007", reg_write, rd, rd_data);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    do_reset();
    rs1 = 5'd0;
    rs2 = 5'd9;
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    next_cycle();
    idle_inputs();
    a_valid = 1'b1;
    a_rd = 5'd9;
    a_data = 32'h0000_0009;
    next_cycle();
    idle_inputs();
    // reg_write to x9 commits at the same edge a new writer of x9 issues.
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    n_checks++;
    if (reg_write !== 1'b1 || rd !== 5'd9) begin
      n_fails++;
      $display("FAIL collision_setup: reg_write=%b rd=%0d, required 1 9", reg_write, rd);
    end
    next_cycle();
    idle_inputs();
    n_checks++;
    if (rs2_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL collision_pending: rs2_busy=%b, required 1", rs2_busy);
    end
    next_cycle();
    n_checks++;
    if (rs2_busy !== 1'b1 || rs1_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL collision_hold: rs2_busy=%b rs1_busy=%b, required 1 0", rs2_busy, rs1_busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails = 0;
    rst = 1'b1;
    idle_inputs();
    rs1 = '0;
    rs2 = '0;
    next_cycle();
    test_reset();
    test_single_port();
    test_contention();
    test_back_to_back();
    test_x0_drop();
    test_scoreboard();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
